// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic ranging post-processing blocks.
package ultrasonic_pkg;

    localparam int unsigned DIST_W      = 9;
    localparam int unsigned MAX_DIST_CM = 400;

    typedef enum logic {
        FAR  = 1'b0,
        NEAR = 1'b1
    } alarm_state_t;

endpackage

// File: rtl/dist_window_sum.sv
// Sliding window of the last 2^DEPTH_LOG2 distance samples with a running sum.
module dist_window_sum #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned DIST_W     = 9
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       sample_valid,
    input  logic [DIST_W-1:0]          sample_dist,
    output logic [DIST_W+DEPTH_LOG2-1:0] sum,
    output logic                       full,
    output logic                       accept,
    output logic [DEPTH_LOG2:0]        fill_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned SUM_W = DIST_W + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

    logic [DIST_W-1:0]     ring_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   fill_q, fill_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic                  acc_q, acc_d;
    logic                  take;
    logic                  full_now;
    logic [SUM_W-1:0]      sample_ext;
    logic [SUM_W-1:0]      oldest_ext;

    assign take       = sample_valid & enable & ~clear;
    assign full_now   = (fill_q == FULL_CNT);
    assign sample_ext = {{DEPTH_LOG2{1'b0}}, sample_dist};
    assign oldest_ext = {{DEPTH_LOG2{1'b0}}, ring_q[wr_ptr_q]};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        sum_d    = sum_q;
        acc_d    = 1'b0;
        if (clear) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            sum_d    = '0;
        end else if (take) begin
            acc_d    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            // Intermediate may wrap, but the true result always fits SUM_W bits.
            if (full_now) begin
                sum_d = sum_q + sample_ext - oldest_ext;
            end else begin
                sum_d  = sum_q + sample_ext;
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            sum_q    <= '0;
            acc_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            sum_q    <= sum_d;
            acc_q    <= acc_d;
        end
    end

    // Ring storage is never reset; stale entries are only subtracted once full.
    always_ff @(posedge PCLK) begin
        if (take) begin
            ring_q[wr_ptr_q] <= sample_dist;
        end
    end

    assign sum        = sum_q;
    assign full       = full_now;
    assign accept     = acc_q;
    assign fill_count = fill_q;

endmodule

// File: rtl/ultrasonic_dist_filter.sv
// Window-average distance filter with a hysteretic proximity alarm and interrupt pulse.
module ultrasonic_dist_filter #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned DIST_W     = ultrasonic_pkg::DIST_W
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                enable,
    input  logic                clear,
    input  logic                sample_valid,
    input  logic [DIST_W-1:0]   sample_dist,
    input  logic [DIST_W-1:0]   thr_near,
    input  logic [DIST_W-1:0]   thr_far,
    output logic [DIST_W-1:0]   avg_dist,
    output logic                avg_valid,
    output logic [DEPTH_LOG2:0] fill_count,
    output logic                near_alarm,
    output logic                alarm_irq
);

    import ultrasonic_pkg::*;

    localparam int unsigned SUM_W = DIST_W + DEPTH_LOG2;

    logic [SUM_W-1:0]  win_sum;
    logic              win_full;
    logic              win_accept;
    logic              sum_frac_unused;

    logic [DIST_W-1:0] avg_q, avg_d;
    logic              avg_valid_q, avg_valid_d;
    logic              irq_q, irq_d;
    alarm_state_t      state_q, state_d;

    dist_window_sum #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DIST_W     (DIST_W)
    ) u_window (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .enable       (enable),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample_dist  (sample_dist),
        .sum          (win_sum),
        .full         (win_full),
        .accept       (win_accept),
        .fill_count   (fill_count)
    );

    // Truncating divide: the fractional bits of the sum are dropped.
    assign sum_frac_unused = ^win_sum[DEPTH_LOG2-1:0];

    always_comb begin
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        state_d     = state_q;
        irq_d       = 1'b0;
        if (clear) begin
            avg_d   = '0;
            state_d = FAR;
        end else begin
            if (win_accept && win_full) begin
                avg_d       = win_sum[SUM_W-1:DEPTH_LOG2];
                avg_valid_d = 1'b1;
            end
            if (avg_valid_q) begin
                case (state_q)
                    FAR: begin
                        if (avg_q < thr_near) begin
                            state_d = NEAR;
                            irq_d   = 1'b1;
                        end
                    end
                    NEAR: begin
                        if (avg_q > thr_far) begin
                            state_d = FAR;
                        end
                    end
                    default: state_d = FAR;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            irq_q       <= 1'b0;
            state_q     <= FAR;
        end else begin
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            irq_q       <= irq_d;
            state_q     <= state_d;
        end
    end

    assign avg_dist   = avg_q;
    assign avg_valid  = avg_valid_q;
    assign near_alarm = (state_q == NEAR);
    assign alarm_irq  = irq_q;

endmodule

// File: tb/tb_ultrasonic_dist_filter.sv
// Directed self-checking bench for ultrasonic_dist_filter (DEPTH_LOG2=2, DIST_W=9).
module tb_ultrasonic_dist_filter;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       enable;
    logic       clear;
    logic       sample_valid;
    logic [8:0] sample_dist;
    logic [8:0] thr_near;
    logic [8:0] thr_far;
    logic [8:0] avg_dist;
    logic       avg_valid;
    logic [2:0] fill_count;
    logic       near_alarm;
    logic       alarm_irq;

    int checks = 0;
    int errors = 0;

    ultrasonic_dist_filter #(
        .DEPTH_LOG2 (2),
        .DIST_W     (9)
    ) dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .enable       (enable),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample_dist  (sample_dist),
        .thr_near     (thr_near),
        .thr_far      (thr_far),
        .avg_dist     (avg_dist),
        .avg_valid    (avg_valid),
        .fill_count   (fill_count),
        .near_alarm   (near_alarm),
        .alarm_irq    (alarm_irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one accept; returns at the falling edge after the accept edge.
    task automatic push(input logic [8:0] v);
        @(negedge PCLK);
        sample_valid = 1'b1;
        sample_dist  = v;
        @(negedge PCLK);
        sample_valid = 1'b0;
    endtask

    // Accept, then check the average one edge later and the pulse end after that.
    task automatic push_chk(input logic [8:0] v, input logic ev, input int ea, input string tag);
        push(v);
        @(negedge PCLK);
        chk({tag, "_valid"}, 32'(avg_valid), 32'(ev));
        chk({tag, "_avg"},   32'(avg_dist),  32'(ea));
        @(negedge PCLK);
        chk({tag, "_pulse_end"}, 32'(avg_valid), 32'd0);
    endtask

    initial begin
        int a55[4];
        a55 = '{43, 47, 51, 55};

        PRESET       = 1'b1;
        enable       = 1'b1;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample_dist  = '0;
        thr_near     = 9'd0;
        thr_far      = 9'd511;
        #12;
        chk("rst_avg",   32'(avg_dist),   32'd0);
        chk("rst_valid", 32'(avg_valid),  32'd0);
        chk("rst_fill",  32'(fill_count), 32'd0);
        chk("rst_near",  32'(near_alarm), 32'd0);
        chk("rst_irq",   32'(alarm_irq),  32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;

        // First fill: no average until the fourth sample.
        push_chk(9'd100, 1'b0, 0, "fill1");
        chk("fill1_cnt", 32'(fill_count), 32'd1);
        push_chk(9'd200, 1'b0, 0, "fill2");
        push_chk(9'd300, 1'b0, 0, "fill3");
        chk("fill3_cnt", 32'(fill_count), 32'd3);
        push_chk(9'd400, 1'b1, 250, "fill4");
        chk("fill4_cnt", 32'(fill_count), 32'd4);

        // Wrap-around subtraction of the oldest entry.
        push_chk(9'd500, 1'b1, 350, "wrap500");
        push_chk(9'd0,   1'b1, 300, "wrap0");
        chk("sat_cnt", 32'(fill_count), 32'd4);

        // Back-to-back samples 1,1,1,2 over ring [500,0,300,400].
        @(negedge PCLK); sample_valid = 1'b1; sample_dist = 9'd1;
        @(negedge PCLK); sample_dist = 9'd1;
        @(negedge PCLK); sample_dist = 9'd1;
        chk("b2b_a225", 32'(avg_dist), 32'd225);
        chk("b2b_v1",   32'(avg_valid), 32'd1);
        @(negedge PCLK); sample_dist = 9'd2;
        chk("b2b_a125", 32'(avg_dist), 32'd125);
        @(negedge PCLK); sample_valid = 1'b0;
        chk("b2b_a0",   32'(avg_dist), 32'd0);
        @(negedge PCLK);
        chk("b2b_trunc", 32'(avg_dist), 32'd1);
        chk("b2b_v4",    32'(avg_valid), 32'd1);
        @(negedge PCLK);
        chk("b2b_end",   32'(avg_valid), 32'd0);

        // Alarm hysteresis.
        @(negedge PCLK); clear = 1'b1;
        @(negedge PCLK); clear = 1'b0;
        chk("clr_fill", 32'(fill_count), 32'd0);
        chk("clr_avg",  32'(avg_dist),   32'd0);
        thr_near = 9'd50;
        thr_far  = 9'd60;
        push_chk(9'd40, 1'b0, 0, "n40a");
        push_chk(9'd40, 1'b0, 0, "n40b");
        push_chk(9'd40, 1'b0, 0, "n40c");
        push_chk(9'd40, 1'b1, 40, "n40d");
        chk("near_set", 32'(near_alarm), 32'd1);
        chk("irq_set",  32'(alarm_irq),  32'd1);
        @(negedge PCLK);
        chk("irq_once", 32'(alarm_irq),  32'd0);
        chk("near_hold0", 32'(near_alarm), 32'd1);
        for (int i = 0; i < 4; i++) begin
            push_chk(9'd55, 1'b1, a55[i], "n55");
            chk("n55_near", 32'(near_alarm), 32'd1);
            chk("n55_irq",  32'(alarm_irq),  32'd0);
        end
        push_chk(9'd70, 1'b1, 58, "f70a");
        chk("f58_near", 32'(near_alarm), 32'd1);
        push_chk(9'd70, 1'b1, 62, "f70b");
        chk("f62_near", 32'(near_alarm), 32'd0);
        chk("f62_irq",  32'(alarm_irq),  32'd0);

        // Clear wins over a same-cycle sample.
        @(negedge PCLK); clear = 1'b1;
        @(negedge PCLK); clear = 1'b0;
        push(9'd20); push(9'd20); push(9'd20);
        chk("pre_clr_cnt", 32'(fill_count), 32'd3);
        @(negedge PCLK); clear = 1'b1; sample_valid = 1'b1; sample_dist = 9'd9;
        @(negedge PCLK); clear = 1'b0; sample_valid = 1'b0;
        chk("clrs_fill", 32'(fill_count), 32'd0);
        chk("clrs_avg",  32'(avg_dist),   32'd0);
        push_chk(9'd8, 1'b0, 0, "e8a");
        push_chk(9'd8, 1'b0, 0, "e8b");
        push_chk(9'd8, 1'b0, 0, "e8c");
        push_chk(9'd8, 1'b1, 8, "e8d");
        chk("e8_irq", 32'(alarm_irq), 32'd1);

        // enable low: samples ignored.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(9'd100);
            @(negedge PCLK);
            chk("dis_valid", 32'(avg_valid), 32'd0);
        end
        chk("dis_fill", 32'(fill_count), 32'd4);
        chk("dis_avg",  32'(avg_dist),   32'd8);
        chk("dis_near", 32'(near_alarm), 32'd1);
        enable = 1'b1;
        push_chk(9'd8, 1'b1, 8, "en8");

        // Asynchronous reset mid-window.
        push(9'd45);
        push(9'd45);
        #2 PRESET = 1'b1;
        #1;
        chk("arst_avg",   32'(avg_dist),   32'd0);
        chk("arst_valid", 32'(avg_valid),  32'd0);
        chk("arst_fill",  32'(fill_count), 32'd0);
        chk("arst_near",  32'(near_alarm), 32'd0);
        chk("arst_irq",   32'(alarm_irq),  32'd0);
        @(negedge PCLK); PRESET = 1'b0;
        push_chk(9'd20, 1'b0, 0, "r20a");
        push_chk(9'd20, 1'b0, 0, "r20b");
        push_chk(9'd20, 1'b0, 0, "r20c");
        push_chk(9'd20, 1'b1, 20, "r20d");
        chk("r20_near", 32'(near_alarm), 32'd1);
        chk("r20_irq",  32'(alarm_irq),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
